// File: rtl/wb_regfile_if.sv
// Bus bundle between the Y86-64 write-back stage and its environment.
// The master drives the executed-instruction fields and read indices; the slave returns read data and status.
interface wb_regfile_if #(parameter int NREG = 15);
    logic                  wb_valid;
    logic [3:0]            icode;
    logic [3:0]            rA;
    logic [3:0]            rB;
    logic                  cnd;
    logic [63:0]           valE;
    logic [63:0]           valM;
    logic [3:0]            srcA;
    logic [3:0]            srcB;
    logic [63:0]           rdA;
    logic [63:0]           rdB;
    logic [64*NREG-1:0]    reg_flat;
    logic                  wb_done;
    logic                  halted;
    logic                  instr_err;

    modport master (
        output wb_valid, icode, rA, rB, cnd, valE, valM, srcA, srcB,
        input  rdA, rdB, reg_flat, wb_done, halted, instr_err
    );

    modport slave (
        input  wb_valid, icode, rA, rB, cnd, valE, valM, srcA, srcB,
        output rdA, rdB, reg_flat, wb_done, halted, instr_err
    );
endinterface

// File: rtl/wb_regfile.sv
// Y86-64 write-back stage and architectural register file, with sticky halt/invalid-instruction status.
// Define WB_BYPASS_EN to forward same-cycle commit data onto the read ports.
module wb_regfile #(
    parameter int          NREG     = 15,
    parameter int          SP_IDX   = 14,
    parameter logic [63:0] SP_RESET = 64'h0000_0000_0000_1000
) (
    input  logic           clk,
    input  logic           rst_n,
    wb_regfile_if.slave    bus
);
    localparam logic [3:0] RNONE    = 4'hF;
    localparam logic [3:0] I_CMOV   = 4'd2;
    localparam logic [3:0] I_IRMOV  = 4'd3;
    localparam logic [3:0] I_MRMOV  = 4'd5;
    localparam logic [3:0] I_OP     = 4'd6;
    localparam logic [3:0] I_CALL   = 4'd8;
    localparam logic [3:0] I_RET    = 4'd9;
    localparam logic [3:0] I_PUSH   = 4'd10;
    localparam logic [3:0] I_POP    = 4'd11;
    localparam logic [3:0] I_HALT   = 4'd0;
    localparam logic [3:0] SP       = 4'(SP_IDX);

    logic [63:0] regs [NREG];
    logic [3:0]  dst_e;
    logic [3:0]  dst_m;
    logic        commit_en;
    logic        wb_done_q;
    logic        halted_q;
    logic        err_q;
    logic [63:0] rd_a;
    logic [63:0] rd_b;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        dst_e = RNONE;
        dst_m = RNONE;
        case (bus.icode)
            I_CMOV:                 dst_e = bus.cnd ? bus.rB : RNONE;
            I_IRMOV, I_OP:          dst_e = bus.rB;
            I_MRMOV:                dst_m = bus.rA;
            I_CALL, I_RET, I_PUSH:  dst_e = SP;
            I_POP: begin
                dst_e = SP;
                dst_m = bus.rA;
            end
            default: ;
        endcase
    end

    // Reset also suppresses the commit so a bypassed read never shows data that is not written.
    assign commit_en = rst_n && bus.wb_valid && !halted_q && !err_q;

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    // NOTE: the register array is a bank of flops rather than a RAM macro, so it is reset word by word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++)
                regs[i] <= (i == SP_IDX) ? SP_RESET : 64'd0;
        end else if (commit_en) begin
            for (int i = 0; i < NREG; i++) begin
                if (dst_m == 4'(i))
                    regs[i] <= bus.valM;
                else if (dst_e == 4'(i))
                    regs[i] <= bus.valE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wb_done_q <= 1'b0;
            halted_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            wb_done_q <= commit_en && (dst_e != RNONE || dst_m != RNONE);
            if (commit_en && bus.icode == I_HALT)
                halted_q <= 1'b1;
            if (commit_en && bus.icode > I_POP)
                err_q <= 1'b1;
        end
    end

    function automatic logic [63:0] array_rd(input logic [3:0] src);
        if (src == RNONE || int'(src) >= NREG)
            return 64'd0;
        return regs[src];
    endfunction

    always_comb begin
        rd_a = array_rd(bus.srcA);
        rd_b = array_rd(bus.srcB);
`ifdef WB_BYPASS_EN
        if (commit_en && bus.srcA != RNONE) begin
            if (bus.srcA == dst_m)
                rd_a = bus.valM;
            else if (bus.srcA == dst_e)
                rd_a = bus.valE;
        end
        if (commit_en && bus.srcB != RNONE) begin
            if (bus.srcB == dst_m)
                rd_b = bus.valM;
            else if (bus.srcB == dst_e)
                rd_b = bus.valE;
        end
`endif
    end

    assign bus.rdA       = rd_a;
    assign bus.rdB       = rd_b;
    assign bus.wb_done   = wb_done_q;
    assign bus.halted    = halted_q;
    assign bus.instr_err = err_q;

    for (genvar g = 0; g < NREG; g++) begin : g_flat
        assign bus.reg_flat[64*g +: 64] = regs[g];
    end
endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: a driver pushes expected observations, a negedge monitor pops and compares.
// Build with +define+WB_BYPASS_EN to check the forwarding variant.
module tb_wb_regfile;
    localparam int NREG = 15;

    typedef struct {
        logic [64*NREG-1:0] flat;
        logic               done;
        logic               h;
        logic               e;
        logic [63:0]        rda;
        logic [63:0]        rdb;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wb_regfile_if #(.NREG(NREG)) bus ();
    wb_regfile #(.NREG(NREG)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;

    logic [63:0] m [NREG];
    bit          mh, me, mdone;

    task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) m[i] = 64'd0;
        m[14] = 64'h1000;
        mh = 0; me = 0; mdone = 0;
    endtask

    // Destinations straight from the instruction-set rules.
    task automatic dests(input logic [3:0] ic, ra, rb, input bit c, output logic [3:0] de, dm);
        de = 4'hF; dm = 4'hF;
        if (ic == 2 && c) de = rb;
        if (ic == 3 || ic == 6) de = rb;
        if (ic == 5) dm = ra;
        if (ic >= 8 && ic <= 11) de = 4'd14;
        if (ic == 11) dm = ra;
    endtask

    function automatic logic [64*NREG-1:0] flat_of();
        logic [64*NREG-1:0] f;
        for (int i = 0; i < NREG; i++) f[64*i +: 64] = m[i];
        return f;
    endfunction

    function automatic logic [63:0] exp_rd(input logic [3:0] s, input bit en,
                                           input logic [3:0] de, dm, input logic [63:0] ve, vm);
        if (s == 4'hF) return 64'd0;
`ifdef WB_BYPASS_EN
        if (en && dm == s) return vm;
        if (en && de == s) return ve;
`endif
        return m[s];
    endfunction

    task automatic step(input bit rst, input bit v, input logic [3:0] ic, ra, rb, input bit c,
                        input logic [63:0] ve, vm, input logic [3:0] sa, sb);
        exp_t e;
        logic [3:0] de, dm;
        bit en;
        @(posedge clk);
        #1;
        rst_n = rst; bus.wb_valid = v; bus.icode = ic; bus.rA = ra; bus.rB = rb;
        bus.cnd = c; bus.valE = ve; bus.valM = vm; bus.srcA = sa; bus.srcB = sb;
        dests(ic, ra, rb, c, de, dm);
        en = rst && v && !mh && !me;
        e.flat = flat_of(); e.done = mdone; e.h = mh; e.e = me;
        e.rda = exp_rd(sa, en, de, dm, ve, vm);
        e.rdb = exp_rd(sb, en, de, dm, ve, vm);
        q.push_back(e);
        if (!rst) begin
            model_reset();
        end else if (en) begin
            if (de != 4'hF) m[de] = ve;
            if (dm != 4'hF) m[dm] = vm;
            mdone = (de != 4'hF) || (dm != 4'hF);
            if (ic == 0) mh = 1;
            if (ic > 11) me = 1;
        end else begin
            mdone = 0;
        end
    endtask

    task automatic idle(input logic [3:0] sa, sb);
        step(1, 0, 4'd1, 4'hF, 4'hF, 0, 64'd0, 64'd0, sa, sb);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check("reg_flat",  bus.reg_flat,  e.flat);
                check("wb_done",   bus.wb_done,   e.done);
                check("halted",    bus.halted,    e.h);
                check("instr_err", bus.instr_err, e.e);
                check("rdA",       bus.rdA,       e.rda);
                check("rdB",       bus.rdB,       e.rdb);
            end
        end
    end

    initial begin : driver
        logic [3:0] ic;
        bit rst;
        model_reset();
        bus.wb_valid = 0; bus.icode = 0; bus.rA = 0; bus.rB = 0; bus.cnd = 0;
        bus.valE = 0; bus.valM = 0; bus.srcA = 4'hF; bus.srcB = 4'hF;

        // Reset held two edges with a competing irmovq that must be dropped.
        step(0, 1, 4'd3, 4'hF, 4'd2, 0, 64'hDEAD, 64'd0, 4'd14, 4'hF);
        step(0, 1, 4'd3, 4'hF, 4'd2, 0, 64'hDEAD, 64'd0, 4'd14, 4'hF);
        step(1, 1, 4'd3, 4'hF, 4'd2, 0, 64'h1234, 64'd0, 4'd2, 4'd14);
        idle(4'd2, 4'hF);
        step(1, 1, 4'd2, 4'hF, 4'd5, 0, 64'h55, 64'd0, 4'd5, 4'd2);
        idle(4'd5, 4'd2);
        step(1, 1, 4'd2, 4'hF, 4'd5, 1, 64'h55, 64'd0, 4'd5, 4'd2);
        idle(4'd5, 4'd14);
        step(1, 1, 4'd11, 4'd14, 4'hF, 0, 64'h1008, 64'hBEEF, 4'd14, 4'd3);
        idle(4'd14, 4'd3);
        step(1, 1, 4'd11, 4'd3, 4'hF, 0, 64'h2000, 64'h3333, 4'd3, 4'd14);
        idle(4'd3, 4'd14);
        step(1, 1, 4'd6, 4'hF, 4'd4, 0, 64'h99, 64'd0, 4'hF, 4'd4);
        idle(4'hF, 4'd4);
        // Halt then a blocked irmovq; reset; invalid icode then a blocked irmovq.
        step(1, 1, 4'd0, 4'hF, 4'hF, 0, 64'd0, 64'd0, 4'd1, 4'hF);
        step(1, 1, 4'd3, 4'hF, 4'd1, 0, 64'd7, 64'd0, 4'd1, 4'hF);
        idle(4'd1, 4'hF);
        step(0, 0, 4'd1, 4'hF, 4'hF, 0, 64'd0, 64'd0, 4'd1, 4'hF);
        step(1, 1, 4'd3, 4'hF, 4'd1, 0, 64'd7, 64'd0, 4'd1, 4'hF);
        step(1, 1, 4'd13, 4'hF, 4'hF, 0, 64'd0, 64'd0, 4'd1, 4'd2);
        step(1, 1, 4'd3, 4'hF, 4'd2, 0, 64'd8, 64'd0, 4'd1, 4'd2);
        idle(4'd1, 4'd2);
        step(0, 0, 4'd1, 4'hF, 4'hF, 0, 64'd0, 64'd0, 4'hF, 4'hF);

        for (int n = 0; n < 400; n++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 3)      ic = 4'd0;
            else if (r < 6) ic = 4'(12 + $urandom_range(0, 3));
            else            ic = 4'(1 + $urandom_range(0, 10));
            rst = ($urandom_range(0, 99) >= 3) && !((mh || me) && $urandom_range(0, 9) < 3);
            step(rst, $urandom_range(0, 3) != 0, ic, 4'($urandom_range(0, 15)),
                 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 {$urandom, $urandom}, {$urandom, $urandom},
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
        end

        @(negedge clk);
        #1;
        check("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
